// File: rtl/serial_pattern_pkg.sv
// Definitions shared by the serial pattern transmitter and its companion receiver.
package serial_pattern_pkg;

  localparam int SERIAL_PATTERN_DEFAULT_WIDTH = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

endpackage

// File: rtl/serial_pattern_transmitter.sv
// LSB-first parallel-to-serial transmitter: valid/ready word load, one bit per step strobe, all outputs registered.
// Defining SERIAL_PATTERN_TX_PARITY_EN appends an even-parity bit after the data bits.
module serial_pattern_transmitter
  import serial_pattern_pkg::*;
#(
  parameter int   WIDTH      = SERIAL_PATTERN_DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load_valid,
  input  logic [WIDTH-1:0]             load_data,
  output logic                         load_ready,
  input  logic                         step,
  output logic                         out,
  output logic                         out_valid,
  output logic                         done,
  output logic [$clog2(WIDTH+2)-1:0]   remaining
);

  localparam int RW = $clog2(WIDTH + 2);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam logic [RW-1:0] FRAME_LEN = RW'(WIDTH + 1);
  localparam logic [RW-1:0] LAST_DATA = RW'(2);
`else
  localparam logic [RW-1:0] FRAME_LEN = RW'(WIDTH);
  localparam logic [RW-1:0] LAST_DATA = RW'(1);
`endif

  tx_state_t        r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_shift,      w_shift_nxt;
  logic [RW-1:0]    r_remaining,  w_remaining_nxt;
  logic             r_out,        w_out_nxt;
  logic             r_out_valid,  w_out_valid_nxt;
  logic             r_done,       w_done_nxt;
  logic             r_load_ready, w_load_ready_nxt;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic             r_parity,     w_parity_nxt;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_remaining  <= '0;
      r_out        <= IDLE_LEVEL;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_remaining  <= w_remaining_nxt;
      r_out        <= w_out_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_done       <= w_done_nxt;
      r_load_ready <= w_load_ready_nxt;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      r_parity     <= w_parity_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_remaining_nxt  = r_remaining;
    w_out_nxt        = r_out;
    w_out_valid_nxt  = r_out_valid;
    w_done_nxt       = 1'b0;
    w_load_ready_nxt = r_load_ready;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    w_parity_nxt     = r_parity;
`endif
    case (r_state)
      IDLE: begin
        // step is deliberately ignored here so bit 0 always gets a full step interval
        if (load_valid) begin
          w_state_nxt      = SHIFT;
          w_shift_nxt      = load_data;
          w_remaining_nxt  = FRAME_LEN;
          w_out_nxt        = load_data[0];
          w_out_valid_nxt  = 1'b1;
          w_load_ready_nxt = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          w_parity_nxt     = ^load_data;
`endif
        end
      end
      SHIFT: begin
        if (step) begin
          w_shift_nxt     = r_shift >> 1;
          w_remaining_nxt = r_remaining - RW'(1);
        end
        // bit 0 of the shift register always mirrors the bit on out
        w_out_nxt = w_shift_nxt[0];
        if (step && (r_remaining == LAST_DATA)) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          w_state_nxt      = PARITY;
          w_out_nxt        = r_parity;
`else
          w_state_nxt      = IDLE;
          w_out_nxt        = IDLE_LEVEL;
          w_out_valid_nxt  = 1'b0;
          w_load_ready_nxt = 1'b1;
          w_done_nxt       = 1'b1;
          w_remaining_nxt  = '0;
`endif
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PARITY: begin
        if (step) begin
          w_state_nxt      = IDLE;
          w_out_nxt        = IDLE_LEVEL;
          w_out_valid_nxt  = 1'b0;
          w_load_ready_nxt = 1'b1;
          w_done_nxt       = 1'b1;
          w_remaining_nxt  = '0;
        end
      end
`endif
      default: begin
        w_state_nxt      = IDLE;
        w_out_nxt        = IDLE_LEVEL;
        w_out_valid_nxt  = 1'b0;
        w_load_ready_nxt = 1'b1;
        w_remaining_nxt  = '0;
      end
    endcase
  end

  assign load_ready = r_load_ready;
  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign done       = r_done;
  assign remaining  = r_remaining;

endmodule
